is_uart_tx: RTL and testbench
=============================

// Module: is_uart_tx
// PURPOSE
//   UART serializer on the transmit side of the lab UART controller. Takes bytes from the
//   controller FSM through a valid/ack handshake. Sends each byte on tx_o as a frame:
//   start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
//   Mirrors the receiver framing, whose parity and frame errors appear as rx_data[9:8].
// PARAMETERS
//   CLK_FREQ    50_000_000  clk_i frequency, Hz
//   BAUD        115200      line rate, bit/s; DIV = (CLK_FREQ + BAUD/2) / BAUD clocks per bit
//   DATA_W      8           data bits per frame
//   PARITY_EN   1           1: parity bit present after the data bits
//   PARITY_ODD  0           0: even parity, 1: odd parity (used only when PARITY_EN=1)
//   STOP_BITS   1           number of stop bits, 1 or 2
// PORTS
//   clk_i       in   1       clock
//   rstn_i      in   1       reset, asynchronous, active-low
//   tx_rdy_t_i  in   1       byte valid, level; held high while the controller has bytes to send
//   tx_data_t_i in   DATA_W  byte to send; sampled only in the accept cycle
//   tx_rdy_r_o  out  1       accept pulse, 1 cycle; the controller may present the next byte after it
//   busy_o      out  1       high from the accept until the last stop-bit clock ends
//   tx_o        out  1       serial line, idle high
// BEHAVIOUR
//   Reset (asynchronous, also mid-frame)
//   - tx_o=1, tx_rdy_r_o=0, busy_o=0, state=IDLE, bit and baud counters=0, shift register=0.
//   - A frame cut by reset is abandoned; no partial-frame recovery.
//   States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE|START. PARITY is skipped if PARITY_EN=0.
//   IDLE
//   - tx_o=1.
//   - If tx_rdy_t_i=1 at a clock edge: latch tx_data_t_i into the shift register and compute the parity bit.
//   - On that same edge: state<=START, tx_o<=0, busy_o<=1, tx_rdy_r_o<=1.
//   - The ack is high exactly the cycle after valid is seen (1-cycle latency).
//   Bit timing
//   - Every bit (start, data, parity, stop) lasts exactly DIV clocks.
//   - The baud counter counts 0..DIV-1; the bit advances at DIV-1, then the counter clears.
//   DATA
//   - tx_o = shift[0]; the register shifts right each bit.
//   - Bit counter runs 0..DATA_W-1, then moves to PARITY, or to STOP if PARITY_EN=0.
//   PARITY
//   - tx_o = ^data, XOR-ed with PARITY_ODD.
//   - Computed from the latched byte, not from the live input.
//   STOP
//   - tx_o=1 for STOP_BITS*DIV clocks.
//   - On the final clock, if tx_rdy_t_i=1: accept a new byte as in IDLE and go straight to START.
//     No idle gap; busy_o stays 1; tx_rdy_r_o pulses.
//   - Otherwise go to IDLE, busy_o<=0.
//   Frame length
//   - DIV*(1+DATA_W+PARITY_EN+STOP_BITS) clocks from the first start-bit clock.
//   - Start-bit falling edge to next start-bit falling edge equals exactly that when back-to-back.
//   Handshake
//   - tx_rdy_t_i and tx_data_t_i are ignored while busy, except on the final stop clock.
//   - The controller changing data after the ack never corrupts the frame in flight.
//   - Valid dropping during a frame has no effect; valid high but never accepted produces no ack.
//   - At most one accept per frame; tx_rdy_r_o is never high 2 cycles in a row.
//   Width/limits
//   - DIV >= 2 required; elaboration error otherwise.
//   - Baud counter width = $clog2(DIV); bit counter width = $clog2(DATA_W+1).
// TESTING (CLK_FREQ=1000, BAUD=100 -> DIV=10, DATA_W=8, PARITY_EN=1, even, 1 stop, frame=110 clk)
//   1 Reset mid-frame
//     - Drive 0x55, assert rstn_i=0 at clock 37.
//     - Required: tx_o=1, busy_o=0, tx_rdy_r_o=0 immediately; no activity until a new valid.
//   2 Single byte 0x55
//     - Required: tx_rdy_r_o 1 cycle after valid, tx_o=0 for 10 clk.
//     - Then 1,0,1,0,1,0,1,0 at 10 clk each, parity 0, stop 1; busy_o high 110 clk.
//   3 Parity
//     - 0x0D even -> parity bit 1; 0x0A even -> 0.
//     - Rerun with PARITY_ODD=1: 0x0D -> 0.
//     - With PARITY_EN=0 the frame is 100 clk.
//   4 Back-to-back CR,LF
//     - Valid held, data changes to 0x0A the cycle after the first ack.
//     - Required: second start bit begins exactly 110 clk after the first; the two acks are 110 clk apart.
//   5 Data change mid-frame
//     - Alter tx_data_t_i every cycle during a frame of 0x3C.
//     - Required: the serial bits still decode as 0x3C with correct parity; the receiver model reports no error.
//   6 STOP_BITS=2
//     - Send 0xFF.
//     - Required: tx_o high for 20 clk after parity; next accept no earlier than clk 120.

Source files
------------

// File: rtl/is_uart_tx.sv
// is_uart_tx -- transmit-side UART serializer.
//
// Accepts a byte through a valid/ack handshake and sends it on tx_o as one frame:
// start bit, DATA_W data bits LSB first, an optional parity bit, then STOP_BITS stop bits.
// Every bit lasts DIV = round(CLK_FREQ / BAUD) clocks. A byte offered on the last clock of
// the stop period is taken immediately, so back-to-back frames have no idle gap.
//
// Ports
//   clk_i        clock
//   rstn_i       asynchronous active-low reset; abandons any frame in flight
//   tx_rdy_t_i   byte valid (level)
//   tx_data_t_i  byte to send, sampled only in the accept cycle
//   tx_rdy_r_o   one-cycle accept pulse, the cycle after valid is taken
//   busy_o       high from the accept until the last stop-bit clock ends
//   tx_o         serial line, idle high

module is_uart_tx #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              tx_rdy_t_i,
   input  logic [DATA_W-1:0] tx_data_t_i,
   output logic              tx_rdy_r_o,
   output logic              busy_o,
   output logic              tx_o
);

   localparam int unsigned DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int unsigned BW  = (DIV >= 2) ? $clog2(DIV) : 1;
   localparam int unsigned CW  = $clog2(DATA_W + 1);

   localparam logic [BW-1:0] BaudLast = BW'(DIV - 1);
   localparam logic [CW-1:0] DataLast = CW'(DATA_W - 1);
   localparam logic [CW-1:0] StopLast = CW'(STOP_BITS - 1);
   localparam logic          ParInit  = (PARITY_ODD != 0);
   localparam logic          HasPar   = (PARITY_EN != 0);

   if (DIV < 2) begin : g_div_chk
      $error("is_uart_tx: CLK_FREQ/BAUD must give at least 2 clocks per bit");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
      $error("is_uart_tx: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e            state_q, state_d;
   logic [BW-1:0]     baud_q, baud_d;
   logic [CW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              ack_q, ack_d;
   logic              bit_end;
   logic              accept;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      ack_d   = 1'b0;
      accept  = 1'b0;
      bit_end = (baud_q == BaudLast);

      if (state_q != StIdle) begin
         baud_d = bit_end ? '0 : baud_q + BW'(1);
      end

      unique case (state_q)
         StIdle: begin
            accept = tx_rdy_t_i;
         end
         StStart: begin
            if (bit_end) state_d = StData;
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == DataLast) begin
                  bit_d   = '0;
                  state_d = HasPar ? StParity : StStop;
               end else begin
                  bit_d = bit_q + CW'(1);
               end
            end
         end
         StParity: begin
            if (bit_end) state_d = StStop;
         end
         StStop: begin
            if (bit_end) begin
               if (bit_q == StopLast) begin
                  bit_d = '0;
                  // Last stop clock: chain straight into the next frame if a byte waits.
                  if (tx_rdy_t_i) accept = 1'b1;
                  else            state_d = StIdle;
               end else begin
                  bit_d = bit_q + CW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         state_d = StStart;
         shift_d = tx_data_t_i;
         // Parity is frozen with the byte so later input changes cannot reach the line.
         par_d   = (^tx_data_t_i) ^ ParInit;
         baud_d  = '0;
         bit_d   = '0;
         ack_d   = 1'b1;
      end

      busy_d = (state_d != StIdle);

      // Line level is registered from the state being entered, keeping tx_o glitch-free.
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
         StParity: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign tx_o       = tx_q;
   assign busy_o     = busy_q;
   assign tx_rdy_r_o = ack_q;

endmodule

// File: tb/tb_is_uart_tx.sv
// Bench for is_uart_tx: five instances with different framing share one stimulus stream.
// A frame-level model (bit index = clocks since accept / DIV) predicts every output each
// cycle; a line receiver decodes the serial output for literal frame checks.

module tb_is_uart_tx;

   localparam int NC = 5;
   localparam int unsigned C_BAUD [NC] = '{100, 100, 100, 100, 280};
   localparam int unsigned C_DW   [NC] = '{8, 8, 8, 8, 5};
   localparam int unsigned C_PEN  [NC] = '{1, 1, 0, 1, 1};
   localparam int unsigned C_ODD  [NC] = '{0, 1, 0, 0, 1};
   localparam int unsigned C_STOP [NC] = '{1, 1, 1, 2, 2};

   logic          clk;
   logic          rstn;
   logic          valid;
   logic [7:0]    data;
   logic [NC-1:0] tx_w;
   logic [NC-1:0] busy_w;
   logic [NC-1:0] ack_w;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      is_uart_tx #(
         .CLK_FREQ  (1000),
         .BAUD      (C_BAUD[g]),
         .DATA_W    (C_DW[g]),
         .PARITY_EN (C_PEN[g]),
         .PARITY_ODD(C_ODD[g]),
         .STOP_BITS (C_STOP[g])
      ) u_dut (
         .clk_i      (clk),
         .rstn_i     (rstn),
         .tx_rdy_t_i (valid),
         .tx_data_t_i(data[C_DW[g]-1:0]),
         .tx_rdy_r_o (ack_w[g]),
         .busy_o     (busy_w[g]),
         .tx_o       (tx_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned div_of(input int i);
      return (1000 + C_BAUD[i] / 2) / C_BAUD[i];
   endfunction

   function automatic int unsigned nbits_of(input int i);
      return 1 + C_DW[i] + C_PEN[i] + C_STOP[i];
   endfunction

   function automatic int unsigned len_of(input int i);
      return div_of(i) * nbits_of(i);
   endfunction

   // Line level t clocks after the accept edge of a frame carrying byte b.
   function automatic logic line_bit(input int i, input logic [7:0] b, input int unsigned t);
      int unsigned k;
      logic        p;
      k = t / div_of(i);
      p = (C_ODD[i] != 0);
      for (int j = 0; j < int'(C_DW[i]); j++) p = p ^ b[j];
      if (k == 0) return 1'b0;
      if (k <= C_DW[i]) return b[k-1];
      if (C_PEN[i] != 0 && k == C_DW[i] + 1) return p;
      return 1'b1;
   endfunction

   // Frame-level reference model.
   logic [NC-1:0] m_act;
   logic [NC-1:0] m_ack;
   logic [NC-1:0] take;
   int unsigned   m_t    [NC];
   logic [7:0]    m_byte [NC];

   always_comb begin
      take = '0;
      for (int i = 0; i < NC; i++) begin
         take[i] = valid && (!m_act[i] || m_t[i] == len_of(i) - 1);
      end
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_act <= '0;
         m_ack <= '0;
         for (int i = 0; i < NC; i++) begin
            m_t[i]    <= 0;
            m_byte[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < NC; i++) begin
            m_ack[i] <= take[i];
            if (take[i]) begin
               m_act[i]  <= 1'b1;
               m_t[i]    <= 0;
               m_byte[i] <= data;
            end else if (m_act[i]) begin
               if (m_t[i] == len_of(i) - 1) m_act[i] <= 1'b0;
               m_t[i] <= m_t[i] + 1;
            end
         end
      end
   end

   int          n_cmp;
   int          n_err;
   int unsigned cyc_n;
   int unsigned run      [NC];
   int unsigned last_run [NC];
   int unsigned last_ack [NC];
   int unsigned prev_ack [NC];
   logic        rx_on    [NC];
   logic        rx_prev  [NC];
   int unsigned rx_t     [NC];
   logic [15:0] rx_word  [NC];
   logic [15:0] rx_last  [NC];
   int unsigned rx_start [NC];
   int unsigned rx_sprev [NC];

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d cyc%0d: got 0x%0h want 0x%0h", name, idx, cyc_n, act, exp);
      end
   endtask

   // One clock: compare against the model on the falling edge, then update the receiver.
   task automatic tick();
      int unsigned k;
      int unsigned d;
      logic        e_tx;
      @(negedge clk);
      cyc_n++;
      for (int i = 0; i < NC; i++) begin
         e_tx = m_act[i] ? line_bit(i, m_byte[i], m_t[i]) : 1'b1;
         check("tx", i, 32'(tx_w[i]), 32'(e_tx));
         check("busy", i, 32'(busy_w[i]), 32'(m_act[i]));
         check("ack", i, 32'(ack_w[i]), 32'(m_ack[i]));

         if (busy_w[i]) run[i]++;
         else if (run[i] != 0) begin
            last_run[i] = run[i];
            run[i]      = 0;
         end
         if (ack_w[i]) begin
            prev_ack[i] = last_ack[i];
            last_ack[i] = cyc_n;
         end

         d = div_of(i);
         if (!rstn) begin
            rx_on[i] = 1'b0;
         end else if (!rx_on[i]) begin
            if (rx_prev[i] && !tx_w[i]) begin
               rx_on[i]    = 1'b1;
               rx_t[i]     = 0;
               rx_word[i]  = '0;
               rx_sprev[i] = rx_start[i];
               rx_start[i] = cyc_n;
            end
         end else begin
            rx_t[i]++;
            if (rx_t[i] % d == d / 2) begin
               k = rx_t[i] / d;
               rx_word[i][k] = tx_w[i];
               if (k == nbits_of(i) - 1) begin
                  rx_on[i]   = 1'b0;
                  rx_last[i] = rx_word[i];
               end
            end
         end
         rx_prev[i] = rstn ? tx_w[i] : 1'b1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      data  = b;
      valid = 1'b1;
      tick();
      check("ack_latency", 0, 32'(ack_w[0]), 32'd1);
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_w != '0 && n < 400) begin
         tick();
         n++;
      end
      check("idle_timeout", 0, 32'(busy_w), 32'd0);
   endtask

   task automatic wait_ack(input int idx);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!ack_w[idx] && n < 300);
      check("ack_timeout", idx, 32'(ack_w[idx]), 32'd1);
   endtask

   int unsigned w55 [NC];
   int unsigned l55 [NC];
   int unsigned p_hi;

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc_n = 0;
      for (int i = 0; i < NC; i++) begin
         run[i]      = 0;
         last_run[i] = 0;
         last_ack[i] = 0;
         prev_ack[i] = 0;
         rx_on[i]    = 1'b0;
         rx_prev[i]  = 1'b1;
         rx_t[i]     = 0;
         rx_word[i]  = '0;
         rx_last[i]  = '0;
         rx_start[i] = 0;
         rx_sprev[i] = 0;
      end
      w55 = '{32'h4AA, 32'h6AA, 32'h2AA, 32'hCAA, 32'h1AA};
      l55 = '{110, 110, 100, 120, 36};
      rstn  = 1'b0;
      valid = 1'b0;
      data  = 8'h00;
      repeat (3) tick();
      check("rst_tx", 0, 32'(tx_w), 32'h1F);
      check("rst_busy", 0, 32'(busy_w), 32'd0);
      check("rst_ack", 0, 32'(ack_w), 32'd0);
      rstn = 1'b1;
      repeat (2) tick();

      // Single byte 0x55 on every framing.
      send(8'h55);
      check("ack_one_cycle", 0, 32'(ack_w[0]), 32'd1);
      tick();
      check("ack_drops", 0, 32'(ack_w[0]), 32'd0);
      wait_idle();
      for (int i = 0; i < NC; i++) begin
         check("frame_55", i, 32'(rx_last[i]), w55[i]);
         check("busy_len_55", i, last_run[i], l55[i]);
      end

      // Parity: even, odd and absent.
      send(8'h0D);
      wait_idle();
      check("frame_0d_even", 0, 32'(rx_last[0]), 32'h61A);
      check("frame_0d_odd", 1, 32'(rx_last[1]), 32'h41A);
      check("frame_0d_nopar", 2, 32'(rx_last[2]), 32'h21A);
      check("busy_len_nopar", 2, last_run[2], 32'd100);
      send(8'h0A);
      wait_idle();
      check("frame_0a_even", 0, 32'(rx_last[0]), 32'h414);

      // Back-to-back CR, LF with the data changing right after the first ack.
      data  = 8'h0D;
      valid = 1'b1;
      tick();
      check("b2b_ack1", 0, 32'(ack_w[0]), 32'd1);
      data = 8'h0A;
      wait_ack(0);
      valid = 1'b0;
      check("b2b_frame1", 0, 32'(rx_last[0]), 32'h61A);
      check("b2b_ack_gap", 0, last_ack[0] - prev_ack[0], 32'd110);
      check("b2b_start_gap", 0, rx_start[0] - rx_sprev[0], 32'd110);
      wait_idle();
      check("b2b_frame2", 0, 32'(rx_last[0]), 32'h414);

      // Input churn while a 0x3C frame is on the line.
      send(8'h3C);
      repeat (115) begin
         data = 8'($urandom);
         tick();
      end
      wait_idle();
      check("churn_frame", 0, 32'(rx_last[0]), 32'h478);

      // Two stop bits: next accept lands exactly one full frame later.
      data  = 8'hFF;
      valid = 1'b1;
      tick();
      data = 8'h00;
      wait_ack(3);
      valid = 1'b0;
      check("stop2_ack_gap", 3, last_ack[3] - prev_ack[3], 32'd120);
      check("stop2_frame_ff", 3, 32'(rx_last[3]), 32'hDFE);
      check("div4_ack_gap", 4, last_ack[4] - prev_ack[4], 32'd36);
      wait_idle();
      check("stop2_frame_00", 3, 32'(rx_last[3]), 32'hC00);

      // Reset 37 clocks into a frame.
      send(8'h55);
      repeat (36) tick();
      rstn = 1'b0;
      #1;
      check("midrst_tx", 0, 32'(tx_w), 32'h1F);
      check("midrst_busy", 0, 32'(busy_w), 32'd0);
      check("midrst_ack", 0, 32'(ack_w), 32'd0);
      repeat (3) tick();
      rstn = 1'b1;
      repeat (30) begin
         tick();
         check("quiet_busy", 0, 32'(busy_w), 32'd0);
         check("quiet_tx", 0, 32'(tx_w), 32'h1F);
      end

      // Random traffic with varying offered load.
      for (int blk = 0; blk < 12; blk++) begin
         case (blk % 4)
            0:       p_hi = 3;
            1:       p_hi = 60;
            2:       p_hi = 100;
            default: p_hi = 15;
         endcase
         repeat (500) begin
            data  = 8'($urandom);
            valid = ($urandom_range(0, 99) < p_hi);
            tick();
         end
      end
      valid = 1'b0;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
